memwrite_scoreboard: RTL and testbench
======================================

// Module: memwrite_scoreboard
// PURPOSE
//  Parametrised successor to the single-write pass check in the MIPS testbench: monitors the core's
//  data-memory write port (memwrite/dataadr/writedata) against a programmable ordered list of expected writes.
//  Reports pass/fail/timeout with a cycle-budget counter; lets each test require several writes, not just one.
//  Sits beside 'top' in the bench (or on-chip for FPGA self-test); one instance per test run, rearmed with start.
// PARAMETERS
//  WIDTH   32  address/data width of monitored write port
//  DEPTH    8  max expected-write entries (>=1); IW = $clog2(DEPTH), CW = $clog2(DEPTH+1)
//  CNTW    16  width of cycle counter / timeout budget
//  STRICT   0  0: non-matching writes counted as stray and ignored; 1: any non-matching write -> FAIL
// PORTS
//  clk          in   1      clock, all state on rising edge
//  reset        in   1      asynchronous, active-high
//  cfg_we       in   1      write expected entry cfg_idx (ignored while busy)
//  cfg_idx      in   IW     entry index
//  cfg_addr     in   WIDTH  expected dataadr
//  cfg_data     in   WIDTH  expected writedata
//  cfg_dataonly in   1      entry compares writedata only (address don't-care)
//  cfg_count    in   CW     number of entries to match, sampled on start (clamped to DEPTH)
//  timeout      in   CNTW   cycle budget, sampled on start; 0 = no timeout
//  start        in   1      arm/rearm check
//  memwrite     in   1      monitored write strobe
//  dataadr      in   WIDTH  monitored address
//  writedata    in   WIDTH  monitored data
//  busy         out  1      check running
//  pass         out  1      all entries matched (sticky until start/reset)
//  fail         out  1      strict mismatch or timeout (sticky until start/reset)
//  timed_out    out  1      budget exhausted (implies fail)
//  match_cnt    out  CW     entries matched so far
//  stray_cnt    out  CNTW   non-matching writes while busy, saturating
//  cycles       out  CNTW   cycles spent busy, saturating
//  bad_addr     out  WIDTH  dataadr of first non-matching write since start
//  bad_data     out  WIDTH  writedata of same
// BEHAVIOUR
//  - Reset (async): state IDLE; all outputs 0; table entries, latched count/timeout cleared to 0.
//  - FSM IDLE -> RUN on start; RUN -> PASS | FAIL; PASS/FAIL -> RUN on start. Start in RUN restarts.
//  - On start: match_cnt, stray_cnt, cycles, bad_* cleared; pass/fail/timed_out cleared; busy=1 next cycle.
//  - cfg_count==0 at start: RUN lasts one cycle, then PASS (pass=1, busy=0).
//  - RUN, each cycle: cycles++ (saturate). If memwrite: compare with entry[match_cnt]:
//      hit when writedata==data && (dataonly || dataadr==addr); hit -> match_cnt++.
//      miss -> stray_cnt++ (saturate); first miss latches bad_addr/bad_data; STRICT=1 -> FAIL.
//  - Write check is registered: pass visible the cycle after the final matching write.
//  - Timeout: timeout!=0 and cycles reaches timeout-1 in RUN without completion -> FAIL, timed_out=1.
//  - Simultaneous final match and timeout in same cycle: PASS wins. Start with memwrite same cycle:
//    write ignored (monitoring begins the cycle after start).
//  - Writes in IDLE/PASS/FAIL ignored; counters frozen. cfg_we while busy ignored; in IDLE/PASS/FAIL
//    writes table; takes effect on next start.
//  - Reset asserted mid-RUN: immediate return to IDLE, all outputs 0, table lost.
//  - pass and fail never both 1; busy=1 only in RUN.
// TESTING
//  1 Load entry0={0x14,21}, count=1, timeout=100, start; drive write 0x14/21 at cycle 5 -> pass=1 cycle 6, match_cnt=1.
//  2 Entries {0x0,4},{0x4,2}, STRICT=0; writes 0x8/9 then 0x0/4 then 0x4/2 -> pass, stray_cnt=1, bad_addr=0x8, bad_data=9.
//  3 Same with STRICT=1 -> fail=1 after 0x8/9, timed_out=0, match_cnt=0.
//  4 count=1, timeout=10, no writes -> fail=1 and timed_out=1 after 10 busy cycles, cycles=10.
//  5 dataonly entry data=479001600; write to 0x7ffffff0/479001600 -> pass; cfg_count=0 start -> pass after 1 cycle.
//  6 Reset pulse mid-RUN after 1 of 2 matches -> all outputs 0 immediately; restart needs table reload.

Source files
------------

// File: rtl/memwrite_scoreboard.sv
// memwrite_scoreboard: checks a memory write port against a programmable ordered list of expected writes
module memwrite_scoreboard #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNTW = 16,
  parameter int STRICT = 0,
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [WIDTH-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             cfg_dataonly,
  input  logic [CW-1:0]    cfg_count,
  input  logic [CNTW-1:0]  timeout,
  input  logic             start,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             timed_out,
  output logic [CW-1:0]    match_cnt,
  output logic [CNTW-1:0]  stray_cnt,
  output logic [CNTW-1:0]  cycles,
  output logic [WIDTH-1:0] bad_addr,
  output logic [WIDTH-1:0] bad_data
);
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] tab_addr [DEPTH];
  logic [WIDTH-1:0] tab_data [DEPTH];
  logic [DEPTH-1:0] tab_do;
  logic [CW-1:0] count;
  logic [CNTW-1:0] budget;
  logic [IW-1:0] idx;
  logic run, hit, miss, done, expire;
  assign run = state == RUN;
  assign busy = run;
  assign pass = state == PASS;
  assign fail = state == FAIL;
  assign idx = match_cnt[IW-1:0];
  assign hit = run && memwrite && match_cnt < count && writedata == tab_data[idx] &&
               (tab_do[idx] || dataadr == tab_addr[idx]);
  assign miss = run && memwrite && !hit && count != '0;
  assign done = run && (count == '0 || (hit && match_cnt + CW'(1) == count));
  assign expire = run && budget != '0 && cycles == budget - CNTW'(1);
  // completion outranks timeout when both land on the same cycle
  always_comb state_n = start ? RUN : done ? PASS : (expire || (STRICT != 0 && miss)) ? FAIL : state;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tab_addr <= '{default: '0};
      tab_data <= '{default: '0};
      tab_do <= '0;
      count <= '0;
      budget <= '0;
      match_cnt <= '0;
      stray_cnt <= '0;
      cycles <= '0;
      bad_addr <= '0;
      bad_data <= '0;
      timed_out <= 1'b0;
    end else begin
      if (cfg_we && !run) begin
        tab_addr[cfg_idx] <= cfg_addr;
        tab_data[cfg_idx] <= cfg_data;
        tab_do[cfg_idx] <= cfg_dataonly;
      end
      if (start) begin
        count <= cfg_count > CW'(DEPTH) ? CW'(DEPTH) : cfg_count;
        budget <= timeout;
        match_cnt <= '0;
        stray_cnt <= '0;
        cycles <= '0;
        bad_addr <= '0;
        bad_data <= '0;
        timed_out <= 1'b0;
      end else if (run) begin
        cycles <= &cycles ? cycles : cycles + CNTW'(1);
        if (hit) match_cnt <= match_cnt + CW'(1);
        if (miss) begin
          stray_cnt <= &stray_cnt ? stray_cnt : stray_cnt + CNTW'(1);
          // stray_cnt saturates and never returns to zero, so zero marks the first miss
          if (stray_cnt == '0) begin
            bad_addr <= dataadr;
            bad_data <= writedata;
          end
        end
        if (expire && !done) timed_out <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_memwrite_scoreboard.sv
// tb_memwrite_scoreboard: random and directed checks of lenient and strict scoreboards against a list-based model
module tb_memwrite_scoreboard;
  logic clk = 0;
  logic reset = 1;
  logic cfg_we = 0, cfg_dataonly = 0, start = 0, memwrite = 0;
  logic [2:0] cfg_idx = 0;
  logic [31:0] cfg_addr = 0, cfg_data = 0, dataadr = 0, writedata = 0;
  logic [3:0] cfg_count = 0;
  logic [15:0] timeout = 0;
  logic busy [2], pass [2], fail [2], timed_out [2];
  logic [3:0] match_cnt [2];
  logic [15:0] stray_cnt [2], cycles [2];
  logic [31:0] bad_addr [2], bad_data [2];
  int checks = 0, errors = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  memwrite_scoreboard #(.STRICT(0)) u0 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_dataonly(cfg_dataonly), .cfg_count(cfg_count), .timeout(timeout),
    .start(start), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(busy[0]), .pass(pass[0]), .fail(fail[0]), .timed_out(timed_out[0]),
    .match_cnt(match_cnt[0]), .stray_cnt(stray_cnt[0]), .cycles(cycles[0]),
    .bad_addr(bad_addr[0]), .bad_data(bad_data[0]));

  memwrite_scoreboard #(.STRICT(1)) u1 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_dataonly(cfg_dataonly), .cfg_count(cfg_count), .timeout(timeout),
    .start(start), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(busy[1]), .pass(pass[1]), .fail(fail[1]), .timed_out(timed_out[1]),
    .match_cnt(match_cnt[1]), .stray_cnt(stray_cnt[1]), .cycles(cycles[1]),
    .bad_addr(bad_addr[1]), .bad_data(bad_data[1]));

  // model: an expected-write list per instance, a pointer into it, and elapsed-cycle bookkeeping
  logic [31:0] ea [2][8], ed [2][8];
  bit eo [2][8];
  int mcount [2], mbudget [2], m_match [2], m_stray [2], m_el [2];
  bit m_busy [2], m_pass [2], m_fail [2], m_to [2], m_hb [2];
  logic [31:0] m_ba [2], m_bd [2];

  always @(posedge clk or posedge reset) begin
    for (int s = 0; s < 2; s++) begin
      if (reset) begin
        for (int i = 0; i < 8; i++) begin ea[s][i] = 0; ed[s][i] = 0; eo[s][i] = 0; end
        mcount[s] = 0; mbudget[s] = 0; m_match[s] = 0; m_stray[s] = 0; m_el[s] = 0;
        m_busy[s] = 0; m_pass[s] = 0; m_fail[s] = 0; m_to[s] = 0; m_hb[s] = 0;
        m_ba[s] = 0; m_bd[s] = 0;
      end else begin
        automatic bit was = m_busy[s];
        if (cfg_we && !was) begin
          ea[s][cfg_idx] = cfg_addr; ed[s][cfg_idx] = cfg_data; eo[s][cfg_idx] = cfg_dataonly;
        end
        if (start) begin
          mcount[s] = cfg_count > 8 ? 8 : int'(cfg_count);
          mbudget[s] = int'(timeout);
          m_match[s] = 0; m_stray[s] = 0; m_el[s] = 0; m_hb[s] = 0; m_ba[s] = 0; m_bd[s] = 0;
          m_busy[s] = 1; m_pass[s] = 0; m_fail[s] = 0; m_to[s] = 0;
        end else if (was) begin
          m_el[s]++;
          if (mcount[s] == 0) m_pass[s] = 1;
          else begin
            if (memwrite && writedata == ed[s][m_match[s]] &&
                (eo[s][m_match[s]] || dataadr == ea[s][m_match[s]])) begin
              m_match[s]++;
              if (m_match[s] == mcount[s]) m_pass[s] = 1;
            end else if (memwrite) begin
              if (!m_hb[s]) begin m_ba[s] = dataadr; m_bd[s] = writedata; end
              m_hb[s] = 1;
              m_stray[s]++;
              if (s == 1) m_fail[s] = 1;
            end
            if (!m_pass[s] && mbudget[s] != 0 && m_el[s] == mbudget[s]) begin
              m_fail[s] = 1; m_to[s] = 1;
            end
          end
          m_busy[s] = !(m_pass[s] || m_fail[s]);
        end
      end
    end
  end

  task automatic chk(input string n, input int s, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[u%0d] got %0h expected %0h at %0t", n, s, a, e, $time);
    end
  endtask

  always @(negedge clk) if (chk_on)
    for (int s = 0; s < 2; s++) begin
      chk("busy", s, 64'(busy[s]), 64'(m_busy[s]));
      chk("pass", s, 64'(pass[s]), 64'(m_pass[s]));
      chk("fail", s, 64'(fail[s]), 64'(m_fail[s]));
      chk("timed_out", s, 64'(timed_out[s]), 64'(m_to[s]));
      chk("match_cnt", s, 64'(match_cnt[s]), 64'(m_match[s]));
      chk("stray_cnt", s, 64'(stray_cnt[s]), 64'(m_stray[s] > 65535 ? 65535 : m_stray[s]));
      chk("cycles", s, 64'(cycles[s]), 64'(m_el[s] > 65535 ? 65535 : m_el[s]));
      chk("bad_addr", s, 64'(bad_addr[s]), 64'(m_ba[s]));
      chk("bad_data", s, 64'(bad_data[s]), 64'(m_bd[s]));
    end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int i, input logic [31:0] a, input logic [31:0] d, input bit o);
    cfg_we = 1; cfg_idx = 3'(i); cfg_addr = a; cfg_data = d; cfg_dataonly = o;
    tick();
    cfg_we = 0;
  endtask

  task automatic arm(input int cnt, input int to);
    start = 1; cfg_count = 4'(cnt); timeout = 16'(to);
    tick();
    start = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1; dataadr = a; writedata = d;
    tick();
    memwrite = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  int r, cnt, to;

  initial begin
    tick(); tick();
    reset = 0;
    chk_on = 1;
    tick();
    chk("reset_busy", 0, 64'(busy[0]), 64'd0);
    chk("reset_pass", 1, 64'(pass[1]), 64'd0);
    // single expected write lands on the fifth running cycle
    load(0, 32'h14, 32'd21, 0);
    arm(1, 100);
    idle(4);
    chk("t1_pre_pass", 0, 64'(pass[0]), 64'd0);
    wr(32'h14, 32'd21);
    chk("t1_pass", 0, 64'(pass[0]), 64'd1);
    chk("t1_match", 0, 64'(match_cnt[0]), 64'd1);
    chk("t1_cycles", 0, 64'(cycles[0]), 64'd5);
    // a stray write ahead of two expected ones
    load(0, 32'h0, 32'd4, 0);
    load(1, 32'h4, 32'd2, 0);
    arm(2, 100);
    wr(32'h8, 32'd9);
    chk("t3_fail", 1, 64'(fail[1]), 64'd1);
    chk("t3_timed_out", 1, 64'(timed_out[1]), 64'd0);
    chk("t3_match", 1, 64'(match_cnt[1]), 64'd0);
    wr(32'h0, 32'd4);
    wr(32'h4, 32'd2);
    chk("t2_pass", 0, 64'(pass[0]), 64'd1);
    chk("t2_stray", 0, 64'(stray_cnt[0]), 64'd1);
    chk("t2_bad_addr", 0, 64'(bad_addr[0]), 64'h8);
    chk("t2_bad_data", 0, 64'(bad_data[0]), 64'd9);
    // budget runs out with nothing written
    arm(1, 10);
    idle(9);
    chk("t4_busy", 0, 64'(busy[0]), 64'd1);
    tick();
    chk("t4_fail", 0, 64'(fail[0]), 64'd1);
    chk("t4_timed_out", 0, 64'(timed_out[0]), 64'd1);
    chk("t4_cycles", 0, 64'(cycles[0]), 64'd10);
    // address-agnostic entry, then an empty list
    load(0, 32'h0, 32'd479001600, 1);
    arm(1, 0);
    wr(32'h7ffffff0, 32'd479001600);
    chk("t5_pass", 0, 64'(pass[0]), 64'd1);
    arm(0, 0);
    chk("t5_busy", 0, 64'(busy[0]), 64'd1);
    tick();
    chk("t5_empty_pass", 0, 64'(pass[0]), 64'd1);
    chk("t5_empty_cycles", 0, 64'(cycles[0]), 64'd1);
    // reset part-way through loses both progress and the table
    load(0, 32'h20, 32'd7, 0);
    load(1, 32'h24, 32'd8, 0);
    arm(2, 100);
    wr(32'h20, 32'd7);
    chk("t6_match", 0, 64'(match_cnt[0]), 64'd1);
    reset = 1;
    #1;
    chk("t6_busy", 0, 64'(busy[0]), 64'd0);
    chk("t6_match0", 0, 64'(match_cnt[0]), 64'd0);
    chk("t6_cycles", 0, 64'(cycles[0]), 64'd0);
    tick();
    reset = 0;
    arm(2, 100);
    wr(32'h20, 32'd7);
    chk("t6_lost_match", 0, 64'(match_cnt[0]), 64'd0);
    chk("t6_lost_stray", 0, 64'(stray_cnt[0]), 64'd1);
    // random traffic with rearm, config writes during runs and the odd reset
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 8; i++)
        load(i, 32'($urandom_range(0, 3) * 4), 32'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
      cnt = $urandom_range(0, 10);
      to = $urandom_range(0, 2) == 0 ? 0 : $urandom_range(4, 30);
      arm(cnt, to);
      for (int c = 0; c < 40; c++) begin
        r = $urandom_range(0, 99);
        if (r < 45 && m_busy[0] && m_match[0] < 8) begin
          memwrite = 1; dataadr = ea[0][m_match[0]]; writedata = ed[0][m_match[0]];
        end else if (r < 65) begin
          memwrite = 1; dataadr = 32'($urandom_range(0, 3) * 4); writedata = 32'($urandom_range(0, 3));
        end
        if ($urandom_range(0, 15) == 0) begin
          cfg_we = 1; cfg_idx = 3'($urandom_range(0, 7));
          cfg_addr = 32'($urandom_range(0, 3) * 4); cfg_data = 32'($urandom_range(0, 3));
          cfg_dataonly = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 49) == 0) begin
          start = 1; cfg_count = 4'($urandom_range(0, 12)); timeout = 16'($urandom_range(0, 20));
        end
        if ($urandom_range(0, 199) == 0) reset = 1;
        tick();
        memwrite = 0; cfg_we = 0; start = 0; reset = 0;
      end
    end
    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
